os_tx_sched: RTL and testbench

//  Ordered-set transmit scheduler between ts_gen and the 128-bit lane TX FIFO.

---
 rtl/os_tx_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_os_tx_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/os_tx_sched.sv
// -----------------------------------------------------------------------------
// os_tx_sched
//   Ordered-set transmit scheduler in front of the 128-bit lane TX FIFO.
//   Three sources share the single FIFO write port:
//     - TS words offered by ts_gen (ts_valid / ts / ts_ready)
//     - periodic SKP ordered sets (only when SKP_SCHED_EN is defined)
//     - EIOS words requested by the LTSSM (eios_req)
//   After the last EIOS word the lane is held in electrical idle until
//   ei_exit is pulsed.
//
//   Build option:
//     SKP_SCHED_EN  defined   -> SKP interval counter, skp_pending, SKP grants
//                   undefined -> no SKP scheduling, skp_pending tied to 0
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     ts_valid, ts    TS word from ts_gen (symbol0 in [127:120])
//     ts_ready        TS word consumed this cycle (same-cycle grant pulse)
//     eios_req        pulse: send EIOS_NUM EIOS words then enter electrical idle
//     ei_exit         pulse: leave electrical idle
//     tx_fifo_full    lane TX FIFO cannot accept a word this cycle
//     tx_valid        FIFO write strobe (registered)
//     tx_data         FIFO write data (registered)
//     tx_os_type      0=TS 1=SKP 2=EIOS, qualified by tx_valid
//     elec_idle       lane held in electrical idle
//     eios_done       1-cycle pulse together with the last EIOS write
//     skp_pending     SKP insertion owed
// -----------------------------------------------------------------------------
module os_tx_sched #(
  parameter int SKP_INTERVAL = 1180,
  parameter int EIOS_NUM     = 1,
  parameter int CNT_W        = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ts_valid,
  input  logic [127:0] ts,
  output logic         ts_ready,
  input  logic         eios_req,
  input  logic         ei_exit,
  input  logic         tx_fifo_full,
  output logic         tx_valid,
  output logic [127:0] tx_data,
  output logic [1:0]   tx_os_type,
  output logic         elec_idle,
  output logic         eios_done,
  output logic         skp_pending
);

  localparam logic [127:0] SKP_WORD  = {4{32'hBC1C_1C1C}};
  localparam logic [127:0] EIOS_WORD = {4{32'hBC7C_7C7C}};
  localparam logic [1:0]   OS_TS     = 2'd0;
  localparam logic [1:0]   OS_SKP    = 2'd1;
  localparam logic [1:0]   OS_EIOS   = 2'd2;

  localparam int              EC_W      = (EIOS_NUM > 1) ? $clog2(EIOS_NUM) : 1;
  localparam logic [EC_W-1:0] EIOS_LAST = EC_W'(EIOS_NUM - 1);

  // The SKP interval has to fit the counter; an out-of-range setting shows up
  // as this named empty block in the elaborated hierarchy.
  localparam bit SKP_CFG_OK = (SKP_INTERVAL >= 1) && (SKP_INTERVAL < (1 << CNT_W));
  generate
    if (!SKP_CFG_OK) begin : g_skp_interval_out_of_range
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_SEND = 2'd0,
    ST_EIOS = 2'd1,
    ST_EI   = 2'd2
  } state_t;

  state_t          state_r;
  logic            eios_pend_r;
  logic [EC_W-1:0] eios_cnt_r;
  logic            tx_valid_r;
  logic [127:0]    tx_data_r;
  logic [1:0]      tx_os_type_r;
  logic            elec_idle_r;
  logic            eios_done_r;

  logic            skp_pend_s;
  logic            go_eios_s;
  logic            gnt_skp_s;
  logic            gnt_ts_s;
  logic            gnt_eios_s;

  // Grant for the single write port; nothing is served while the FIFO is full.
  // In SEND a pending EIOS request wins the slot but only moves the FSM to
  // EIOS, so no word is written in that cycle.
  always_comb begin
    go_eios_s  = 1'b0;
    gnt_skp_s  = 1'b0;
    gnt_ts_s   = 1'b0;
    gnt_eios_s = 1'b0;
    if (tx_fifo_full) begin
      go_eios_s = 1'b0;
    end else begin
      case (state_r)
        ST_SEND: begin
          if (eios_pend_r) begin
            go_eios_s = 1'b1;
          end else if (skp_pend_s) begin
            gnt_skp_s = 1'b1;
          end else if (ts_valid) begin
            gnt_ts_s = 1'b1;
          end else begin
            gnt_ts_s = 1'b0;
          end
        end
        ST_EIOS: gnt_eios_s = 1'b1;
        ST_EI:   gnt_eios_s = 1'b0;
        default: gnt_eios_s = 1'b0;
      endcase
    end
  end

  // ts_gen sees the grant in the same cycle; held low while in reset.
  assign ts_ready = gnt_ts_s & ~rst;

  // Scheduler FSM plus registered FIFO write port and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_SEND;
      eios_pend_r  <= 1'b0;
      eios_cnt_r   <= {EC_W{1'b0}};
      tx_valid_r   <= 1'b0;
      tx_data_r    <= 128'h0;
      tx_os_type_r <= OS_TS;
      elec_idle_r  <= 1'b0;
      eios_done_r  <= 1'b0;
    end else begin
      eios_done_r <= 1'b0;
      tx_valid_r  <= gnt_ts_s | gnt_skp_s | gnt_eios_s;

      if (gnt_ts_s) begin
        tx_data_r    <= ts;
        tx_os_type_r <= OS_TS;
      end else if (gnt_skp_s) begin
        tx_data_r    <= SKP_WORD;
        tx_os_type_r <= OS_SKP;
      end else if (gnt_eios_s) begin
        tx_data_r    <= EIOS_WORD;
        tx_os_type_r <= OS_EIOS;
      end else begin
        tx_data_r    <= tx_data_r;
        tx_os_type_r <= tx_os_type_r;
      end

      case (state_r)
        ST_SEND: begin
          if (go_eios_s) begin
            state_r     <= ST_EIOS;
            eios_pend_r <= 1'b0;
          end else if (eios_req) begin
            eios_pend_r <= 1'b1;
          end else begin
            eios_pend_r <= eios_pend_r;
          end
        end
        ST_EIOS: begin
          if (gnt_eios_s) begin
            if (eios_cnt_r == EIOS_LAST) begin
              eios_cnt_r  <= {EC_W{1'b0}};
              eios_done_r <= 1'b1;
              elec_idle_r <= 1'b1;
              state_r     <= ST_EI;
            end else begin
              eios_cnt_r <= eios_cnt_r + EC_W'(1);
            end
          end
        end
        ST_EI: begin
          if (ei_exit) begin
            state_r     <= ST_SEND;
            elec_idle_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_SEND;
          eios_pend_r <= 1'b0;
          eios_cnt_r  <= {EC_W{1'b0}};
          elec_idle_r <= 1'b0;
        end
      endcase
    end
  end

  assign tx_valid   = tx_valid_r;
  assign tx_data    = tx_data_r;
  assign tx_os_type = tx_os_type_r;
  assign elec_idle  = elec_idle_r;
  assign eios_done  = eios_done_r;

`ifdef SKP_SCHED_EN
  localparam logic [CNT_W-1:0] SKP_LAST = CNT_W'(SKP_INTERVAL - 1);

  logic [CNT_W-1:0] skp_cnt_r;
  logic             skp_pending_r;

  // SKP interval counter: frozen in electrical idle, restarted on idle exit.
  // Expiry has precedence over a same-cycle SKP grant so that an SKP owed by
  // the new interval is never dropped; pending never accumulates past one.
  always_ff @(posedge clk) begin
    if (rst) begin
      skp_cnt_r     <= {CNT_W{1'b0}};
      skp_pending_r <= 1'b0;
    end else if (state_r == ST_EI) begin
      if (ei_exit) begin
        skp_cnt_r     <= {CNT_W{1'b0}};
        skp_pending_r <= 1'b0;
      end
    end else if (skp_cnt_r == SKP_LAST) begin
      skp_cnt_r     <= {CNT_W{1'b0}};
      skp_pending_r <= 1'b1;
    end else begin
      skp_cnt_r <= skp_cnt_r + CNT_W'(1);
      if (gnt_skp_s) begin
        skp_pending_r <= 1'b0;
      end
    end
  end

  assign skp_pend_s  = skp_pending_r;
  assign skp_pending = skp_pending_r;
`else
  assign skp_pend_s  = 1'b0;
  assign skp_pending = 1'b0;
`endif

endmodule

// File: tb/tb_os_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_os_tx_sched
//   Directed bench for os_tx_sched with SKP_INTERVAL=8, EIOS_NUM=2.
//   A small ts_gen stand-in offers numbered TS words and advances on ts_ready;
//   every TS write must carry the next number in order (no loss, no repeats).
//   SKP expectations depend on whether SKP_SCHED_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_os_tx_sched;

  localparam int SKP_INTERVAL = 8;
  localparam int EIOS_NUM     = 2;
  localparam int CNT_W        = 11;

`ifdef SKP_SCHED_EN
  localparam bit SKP_ON = 1'b1;
`else
  localparam bit SKP_ON = 1'b0;
`endif

  localparam logic [127:0] SKP_W  = {4{32'hBC1C_1C1C}};
  localparam logic [127:0] EIOS_W = {4{32'hBC7C_7C7C}};

  logic         clk = 1'b0;
  logic         rst;
  logic         ts_valid;
  logic [127:0] ts;
  logic         ts_ready;
  logic         eios_req;
  logic         ei_exit;
  logic         tx_fifo_full;
  logic         tx_valid;
  logic [127:0] tx_data;
  logic [1:0]   tx_os_type;
  logic         elec_idle;
  logic         eios_done;
  logic         skp_pending;

  int   vectors     = 0;
  int   miscompares = 0;
  int   ts_idx      = 0;
  int   exp_wr      = 0;
  logic rdy_seen    = 1'b0;

  os_tx_sched #(
    .SKP_INTERVAL(SKP_INTERVAL),
    .EIOS_NUM    (EIOS_NUM),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ts_valid    (ts_valid),
    .ts          (ts),
    .ts_ready    (ts_ready),
    .eios_req    (eios_req),
    .ei_exit     (ei_exit),
    .tx_fifo_full(tx_fifo_full),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_os_type  (tx_os_type),
    .elec_idle   (elec_idle),
    .eios_done   (eios_done),
    .skp_pending (skp_pending)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input int i);
    return {32'hC0DE_0000 + 32'(i), 64'h0123_4567_89AB_CDEF, 32'(i)};
  endfunction

  // One clock: ts_ready sampled just before the edge, outputs settle 1 after.
  task automatic tick();
    #1;
    rdy_seen = ts_ready;
    @(posedge clk);
    #1;
    if (rdy_seen) begin
      ts_idx++;
      ts = mk(ts_idx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ts_valid = 1'b1; ts = mk(0); eios_req = 1'b0;
    ei_exit = 1'b0; tx_fifo_full = 1'b0;
    tick(); tick();
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    vectors++; if (tx_data !== 128'h0) begin miscompares++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
    vectors++; if (tx_os_type !== 2'd0) begin miscompares++; $display("FAIL reset_tx_os_type: got %0d want 0", tx_os_type); end
    vectors++; if (elec_idle !== 1'b0) begin miscompares++; $display("FAIL reset_elec_idle: got %b want 0", elec_idle); end
    vectors++; if (eios_done !== 1'b0) begin miscompares++; $display("FAIL reset_eios_done: got %b want 0", eios_done); end
    vectors++; if (skp_pending !== 1'b0) begin miscompares++; $display("FAIL reset_skp_pending: got %b want 0", skp_pending); end
    vectors++; if (rdy_seen !== 1'b0) begin miscompares++; $display("FAIL reset_ts_ready: got %b want 0", rdy_seen); end
  endtask

  // Continuous TS offer from reset: with SKP scheduling the first SKP follows
  // edge 8 and then one SKP every 8 writes (7 TS + 1 SKP).
  task automatic test_ts_stream();
    logic exp_skp;
    rst = 1'b0;
    exp_wr = ts_idx;
    for (int n = 1; n <= 24; n++) begin
      tick();
      exp_skp = SKP_ON && (n >= 9) && ((n % 8) == 1);
      vectors++; if (tx_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid n=%0d: got %b want 1", n, tx_valid); end
      vectors++; if (rdy_seen !== !exp_skp) begin miscompares++; $display("FAIL stream_ts_ready n=%0d: got %b want %b", n, rdy_seen, !exp_skp); end
      if (exp_skp) begin
        vectors++; if (tx_os_type !== 2'd1 || tx_data !== SKP_W) begin miscompares++; $display("FAIL stream_skp n=%0d: got type %0d data %h want SKP", n, tx_os_type, tx_data); end
      end else begin
        vectors++; if (tx_os_type !== 2'd0 || tx_data !== mk(exp_wr)) begin miscompares++; $display("FAIL stream_ts n=%0d: got type %0d data %h want %h", n, tx_os_type, tx_data, mk(exp_wr)); end
        exp_wr++;
      end
    end
  endtask

  task automatic test_fifo_full();
    tx_fifo_full = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL full_tx_valid i=%0d: got %b want 0", i, tx_valid); end
      vectors++; if (rdy_seen !== 1'b0) begin miscompares++; $display("FAIL full_ts_ready i=%0d: got %b want 0", i, rdy_seen); end
    end
    tx_fifo_full = 1'b0;
    tick();
    if (SKP_ON) begin
      vectors++; if (tx_valid !== 1'b1 || tx_os_type !== 2'd1 || tx_data !== SKP_W) begin miscompares++; $display("FAIL full_release_skp: got v%b type %0d data %h want SKP", tx_valid, tx_os_type, tx_data); end
    end else begin
      vectors++; if (tx_valid !== 1'b1 || tx_os_type !== 2'd0 || tx_data !== mk(exp_wr)) begin miscompares++; $display("FAIL full_release_ts: got v%b type %0d data %h want %h", tx_valid, tx_os_type, tx_data, mk(exp_wr)); end
      exp_wr++;
    end
    tick();
    vectors++; if (tx_valid !== 1'b1 || tx_os_type !== 2'd0 || tx_data !== mk(exp_wr)) begin miscompares++; $display("FAIL full_resume_ts: got v%b type %0d data %h want %h", tx_valid, tx_os_type, tx_data, mk(exp_wr)); end
    exp_wr++;
  endtask

  task automatic test_eios();
`ifdef SKP_SCHED_EN
    int w;
    w = 0;
    while (skp_pending !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    vectors++; if (skp_pending !== 1'b1) begin miscompares++; $display("FAIL eios_wait_skp_pending: got %b want 1 (timeout)", skp_pending); end
`endif
    eios_req = 1'b1;
    tick();
    eios_req = 1'b0;
    tick();
    vectors++; if (tx_valid !== 1'b0 || rdy_seen !== 1'b0) begin miscompares++; $display("FAIL eios_enter: got v%b rdy%b want v0 rdy0", tx_valid, rdy_seen); end
    tick();
    vectors++; if (tx_valid !== 1'b1 || tx_os_type !== 2'd2 || tx_data !== EIOS_W) begin miscompares++; $display("FAIL eios_word1: got v%b type %0d data %h want EIOS", tx_valid, tx_os_type, tx_data); end
    vectors++; if (eios_done !== 1'b0 || elec_idle !== 1'b0) begin miscompares++; $display("FAIL eios_word1_status: got done%b idle%b want done0 idle0", eios_done, elec_idle); end
    tick();
    vectors++; if (tx_valid !== 1'b1 || tx_os_type !== 2'd2 || tx_data !== EIOS_W) begin miscompares++; $display("FAIL eios_word2: got v%b type %0d data %h want EIOS", tx_valid, tx_os_type, tx_data); end
    vectors++; if (eios_done !== 1'b1 || elec_idle !== 1'b1) begin miscompares++; $display("FAIL eios_word2_status: got done%b idle%b want done1 idle1", eios_done, elec_idle); end
    for (int i = 0; i < 50; i++) begin
      eios_req = (i == 10);
      tick();
      vectors++; if (tx_valid !== 1'b0 || rdy_seen !== 1'b0) begin miscompares++; $display("FAIL ei_quiet i=%0d: got v%b rdy%b want v0 rdy0", i, tx_valid, rdy_seen); end
      vectors++; if (elec_idle !== 1'b1 || eios_done !== 1'b0) begin miscompares++; $display("FAIL ei_status i=%0d: got idle%b done%b want idle1 done0", i, elec_idle, eios_done); end
    end
    eios_req = 1'b0;
  endtask

  // Idle exit: TS resumes at once; with SKP scheduling the first SKP is the
  // 9th write after the exit edge. A stray ei_exit in SEND changes nothing.
  task automatic test_ei_exit();
    logic exp_skp;
    ei_exit = 1'b1;
    tick();
    ei_exit = 1'b0;
    vectors++; if (elec_idle !== 1'b0 || tx_valid !== 1'b0) begin miscompares++; $display("FAIL exit_status: got idle%b v%b want idle0 v0", elec_idle, tx_valid); end
    exp_wr = ts_idx;
    for (int k = 1; k <= 12; k++) begin
      ei_exit = (k == 3);
      tick();
      exp_skp = SKP_ON && (k == 9);
      vectors++; if (tx_valid !== 1'b1 || elec_idle !== 1'b0) begin miscompares++; $display("FAIL exit_valid k=%0d: got v%b idle%b want v1 idle0", k, tx_valid, elec_idle); end
      if (exp_skp) begin
        vectors++; if (tx_os_type !== 2'd1 || tx_data !== SKP_W) begin miscompares++; $display("FAIL exit_skp k=%0d: got type %0d data %h want SKP", k, tx_os_type, tx_data); end
      end else begin
        vectors++; if (tx_os_type !== 2'd0 || tx_data !== mk(exp_wr)) begin miscompares++; $display("FAIL exit_ts k=%0d: got type %0d data %h want %h", k, tx_os_type, tx_data, mk(exp_wr)); end
        exp_wr++;
      end
    end
    ei_exit = 1'b0;
  endtask

  task automatic test_rst_mid_eios();
    eios_req = 1'b1;
    tick();
    eios_req = 1'b0;
    tick();
    tick();
    vectors++; if (tx_valid !== 1'b1 || tx_os_type !== 2'd2) begin miscompares++; $display("FAIL rst_pre_eios: got v%b type %0d want v1 type 2", tx_valid, tx_os_type); end
    rst = 1'b1;
    tick();
    vectors++; if (tx_valid !== 1'b0 || tx_data !== 128'h0 || tx_os_type !== 2'd0) begin miscompares++; $display("FAIL rst_mid_port: got v%b type %0d data %h want all 0", tx_valid, tx_os_type, tx_data); end
    vectors++; if (elec_idle !== 1'b0 || eios_done !== 1'b0 || skp_pending !== 1'b0 || rdy_seen !== 1'b0) begin miscompares++; $display("FAIL rst_mid_status: got idle%b done%b skp%b rdy%b want 0000", elec_idle, eios_done, skp_pending, rdy_seen); end
    rst = 1'b0;
    exp_wr = ts_idx;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++; if (tx_valid !== 1'b1 || tx_os_type !== 2'd0 || tx_data !== mk(exp_wr) || elec_idle !== 1'b0) begin miscompares++; $display("FAIL rst_resume_ts k=%0d: got v%b type %0d data %h idle%b want TS %h", k, tx_valid, tx_os_type, tx_data, elec_idle, mk(exp_wr)); end
      exp_wr++;
    end
  endtask

  task automatic test_long_stream();
    logic exp_skp;
    int   skp_seen;
    skp_seen = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_wr = ts_idx;
    for (int n = 1; n <= 5000; n++) begin
      tick();
      exp_skp = SKP_ON && (n >= 9) && ((n % 8) == 1);
      if (tx_valid === 1'b1 && tx_os_type === 2'd1) skp_seen++;
      if (exp_skp) begin
        vectors++; if (tx_valid !== 1'b1 || tx_os_type !== 2'd1) begin miscompares++; $display("FAIL long_skp n=%0d: got v%b type %0d want SKP", n, tx_valid, tx_os_type); end
      end else begin
        vectors++; if (tx_valid !== 1'b1 || tx_os_type !== 2'd0 || tx_data !== mk(exp_wr)) begin miscompares++; $display("FAIL long_ts n=%0d: got v%b type %0d data %h want %h", n, tx_valid, tx_os_type, tx_data, mk(exp_wr)); end
        exp_wr++;
      end
`ifndef SKP_SCHED_EN
      vectors++; if (skp_pending !== 1'b0) begin miscompares++; $display("FAIL long_skp_pending n=%0d: got %b want 0", n, skp_pending); end
`endif
    end
    vectors++; if (skp_seen !== (SKP_ON ? 624 : 0)) begin miscompares++; $display("FAIL long_skp_count: got %0d want %0d", skp_seen, (SKP_ON ? 624 : 0)); end
  endtask

  initial begin
    test_reset();
    test_ts_stream();
    test_fifo_full();
    test_eios();
    test_ei_exit();
    test_rst_mid_eios();
    test_long_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
